// File: rtl/audio_pkg.sv
// audio_pkg: shared constants and FSM encoding for the sample feeder.
package audio_pkg;
    localparam logic [7:0] SILENCE   = 8'h80;
    localparam logic [3:0] VOL_RESET = 4'd8;
    typedef enum logic {FILL = 1'b0, PLAY = 1'b1} state_t;
endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: power-of-two sample FIFO; pointers wrap naturally, storage is unreset.
module sample_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        full,
    output logic        empty,
    output logic [AW:0] level
);
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          push_ok, pop_ok;

    always_comb begin
        full    = lvl_q == (AW+1)'(DEPTH);
        empty   = lvl_q == '0;
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wr_d    = wr_q + AW'(push_ok);
        rd_d    = rd_q + AW'(pop_ok);
        lvl_d   = lvl_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        dout    = mem_q[rd_q];
        level   = lvl_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/sample_feeder.sv
// sample_feeder: paces FIFO samples out to a PWM stage, one per PWM frame,
// with fill/play priming, underrun signalling and a saturating volume.
module sample_feeder
    import audio_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int PERIOD = 4096,
    parameter int PRIME  = DEPTH / 2,
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          vol_up,
    input  logic          vol_dn,
    output logic [7:0]    duty,
    output logic [3:0]    vol,
    output logic          underrun,
    output logic [LW-1:0] level
);
    localparam logic [11:0]   LAST      = 12'(PERIOD - 1);
    localparam logic [LW-1:0] PRIME_LVL = LW'(PRIME);

    state_t      state_q, state_d;
    logic [11:0] cnt_q, cnt_d;
    logic [7:0]  duty_q, duty_d, head;
    logic [3:0]  vol_q, vol_d;
    logic        underrun_q, underrun_d;
    logic        tick, push, pop, full, empty;

    sample_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (in_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        tick       = cnt_q == LAST;
        cnt_d      = tick ? 12'd0 : cnt_q + 12'd1;
        in_ready   = !full;
        push       = in_valid && !full;
        pop        = state_q == PLAY && tick && !empty;
        state_d    = state_q;
        duty_d     = duty_q;
        underrun_d = 1'b0;
        if (tick) begin
            if (state_q == FILL) begin
                state_d = level >= PRIME_LVL ? PLAY : FILL;
            end else if (empty) begin
                state_d    = FILL;
                duty_d     = SILENCE;
                underrun_d = 1'b1;
            end else begin
                duty_d = head;
            end
        end
        // simultaneous up and down cancel out
        vol_d = vol_up && !vol_dn && vol_q != 4'hF ? vol_q + 4'd1 :
                vol_dn && !vol_up && vol_q != 4'h0 ? vol_q - 4'd1 : vol_q;
        duty     = duty_q;
        vol      = vol_q;
        underrun = underrun_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            cnt_q      <= '0;
            duty_q     <= SILENCE;
            vol_q      <= VOL_RESET;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            duty_q     <= duty_d;
            vol_q      <= vol_d;
            underrun_q <= underrun_d;
        end
    end
endmodule

// File: tb/tb_sample_feeder.sv
// tb_sample_feeder: scoreboard of accepted samples checked against DUTY at each
// frame tick, plus a volume vector table and mid-playback reset sequence.
module tb_sample_feeder;
    localparam int DEPTH  = 16;
    localparam int PERIOD = 16;
    localparam int PRIME  = 8;
    localparam int LW     = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          vol_up = 1'b0;
    logic          vol_dn = 1'b0;
    logic [7:0]    duty;
    logic [3:0]    vol;
    logic          underrun;
    logic [LW-1:0] level;

    sample_feeder #(.DEPTH(DEPTH), .PERIOD(PERIOD), .PRIME(PRIME)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .vol_up   (vol_up),
        .vol_dn   (vol_dn),
        .duty     (duty),
        .vol      (vol),
        .underrun (underrun),
        .level    (level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       up;
        logic       dn;
        logic [3:0] vol;
    } vrec_t;

    vrec_t      vt [33];
    logic [7:0] exp_q [$];
    logic [7:0] exp_duty;
    logic       exp_under;
    logic       play;
    logic       last_acc;
    int         tb_cnt;
    int         n_tests = 0;
    int         n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        play      = 1'b0;
        tb_cnt    = 0;
        exp_duty  = 8'h80;
        exp_under = 1'b0;
        last_acc  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_duty"}, 32'(duty), 32'h80);
        chk({tag, "_vol"}, 32'(vol), 32'd8);
        chk({tag, "_level"}, 32'(level), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    // one clock: predict from pre-edge state, then compare just after the edge
    task automatic step();
        logic acc, tk;
        acc = in_valid && exp_q.size() < DEPTH;
        tk  = tb_cnt == PERIOD - 1;
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        @(posedge clk);
        #1;
        exp_under = 1'b0;
        if (tk) begin
            if (!play) begin
                if (exp_q.size() >= PRIME) play = 1'b1;
            end else if (exp_q.size() == 0) begin
                exp_duty  = 8'h80;
                exp_under = 1'b1;
                play      = 1'b0;
            end else begin
                exp_duty = exp_q.pop_front();
            end
        end
        if (acc) exp_q.push_back(in_data);
        last_acc = acc;
        tb_cnt   = tk ? 0 : tb_cnt + 1;
        chk("duty", 32'(duty), 32'(exp_duty));
        chk("underrun", 32'(underrun), 32'(exp_under));
        chk("level", 32'(level), 32'(exp_q.size()));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_seq(input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = base + 8'(i);
            step();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        chk("ready_after_release", 32'(in_ready), 32'd1);

        idle(2 * PERIOD);

        push_seq(8'h10, 16);
        chk("full_level", 32'(level), 32'd16);
        in_valid = 1'b1;
        in_data  = 8'h20;
        step();
        chk("push17_rejected", 32'(last_acc), 32'd0);
        for (int i = 0; i < 3 * PERIOD && !last_acc; i++) step();
        chk("held_push_accepted", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        idle(20 * PERIOD);

        push_seq(8'h30, 8);
        idle(12 * PERIOD);
        push_seq(8'h50, 8);
        idle(3 * PERIOD);

        begin
            int budget = 20 * PERIOD;
            while (!(play && exp_q.size() == 0 && tb_cnt == PERIOD - 1) && budget > 0) begin
                step();
                budget--;
            end
            chk("align_underrun_tick", 32'(budget > 0), 32'd1);
        end
        in_valid = 1'b1;
        in_data  = 8'h99;
        step();
        chk("tick_push_underrun", 32'(underrun), 32'd1);
        in_valid = 1'b0;
        push_seq(8'hA0, 7);
        idle(10 * PERIOD);

        for (int i = 0; i < 10; i++) vt[i] = '{1'b1, 1'b0, 4'((8 + i + 1) > 15 ? 15 : 8 + i + 1)};
        vt[10] = '{1'b1, 1'b1, 4'd15};
        for (int i = 0; i < 20; i++) vt[11 + i] = '{1'b0, 1'b1, 4'((15 - i - 1) < 0 ? 0 : 15 - i - 1)};
        vt[31] = '{1'b1, 1'b1, 4'd0};
        vt[32] = '{1'b1, 1'b0, 4'd1};
        for (int i = 0; i < 33; i++) begin
            vol_up = vt[i].up;
            vol_dn = vt[i].dn;
            step();
            chk($sformatf("vol_vec%0d", i), 32'(vol), 32'(vt[i].vol));
        end
        vol_up = 1'b0;
        vol_dn = 1'b0;

        push_seq(8'h60, 12);
        idle(2 * PERIOD + 3);
        chk("playing_before_reset", 32'(play), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        idle(3 * PERIOD);
        push_seq(8'h70, 8);
        idle(4 * PERIOD);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_feeder.md
SAMPLE_FEEDER -- requirements
Module: sample_feeder

Interface
REQ-001 Parameter DEPTH, default 16, SHALL set the FIFO entries and be a power of two, 4 or more.
REQ-002 Parameter PERIOD, default 4096, SHALL set the clocks per output sample, equal to the downstream 12-bit PWM frame.
REQ-003 Parameter PRIME, default DEPTH/2, SHALL set the FIFO level needed to start or resume playback.
REQ-004 CLK  input  1  sole clock, rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 IN_DATA  input  8  unsigned audio sample, 0x80 = silence.
REQ-007 IN_VALID  input  1  IN_DATA is valid this cycle.
REQ-008 IN_READY  output  1  FIFO can accept a sample this cycle.
REQ-009 VOL_UP  input  1  single-cycle volume increment request.
REQ-010 VOL_DN  input  1  single-cycle volume decrement request.
REQ-011 DUTY  output  8  current sample to the PWM stage.
REQ-012 VOL  output  4  current volume to the PWM stage.
REQ-013 UNDERRUN  output  1  one-cycle pulse when a sample tick finds the FIFO empty while playing.
REQ-014 LEVEL  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 A push SHALL occur on any rising edge where IN_VALID and IN_READY are both 1.
REQ-016 IN_READY SHALL be the combinational inverse of FIFO-full and SHALL NOT depend on IN_VALID.
REQ-017 A 12-bit tick counter SHALL count 0..PERIOD-1 and wrap; TICK is asserted in the cycle the count equals PERIOD-1.
REQ-018 The FSM SHALL have two states, FILL and PLAY.
REQ-019 FILL->PLAY: SHALL occur when LEVEL >= PRIME at a TICK.
REQ-020 PLAY->FILL: SHALL occur when the FIFO is empty at a TICK.
REQ-021 In PLAY, at a TICK with the FIFO non-empty, the head entry SHALL be popped and registered into DUTY; DUTY updates on the next edge, which coincides with PWM counter wrap.
REQ-022 In PLAY, at a TICK with the FIFO empty, DUTY SHALL load 0x80 and UNDERRUN SHALL pulse for exactly one cycle.
REQ-023 In FILL, DUTY SHALL hold 0x80 and no pop SHALL occur.
REQ-024 A push and a pop in the same cycle SHALL leave LEVEL unchanged and preserve FIFO order.
REQ-025 A push into an empty FIFO in the TICK cycle SHALL NOT be popped in that cycle; this is an underrun.
REQ-026 VOL SHALL saturate at 15 on VOL_UP and at 0 on VOL_DN, with no wrap-around.
REQ-027 VOL_UP and VOL_DN asserted together SHALL leave VOL unchanged.
REQ-028 DUTY, VOL and UNDERRUN SHALL be registered outputs with no combinational path from inputs.

Reset
REQ-029 While RST_N = 0, all state SHALL clear asynchronously to: FILL, counter 0, FIFO empty (LEVEL 0), DUTY 0x80, VOL 8, UNDERRUN 0.
REQ-030 IN_READY SHALL read 1 on the first edge after RST_N deasserts.
REQ-031 Reset asserted mid-playback SHALL discard all FIFO contents; no sample SHALL be emitted after release until the FIFO re-primes.

Structure
REQ-032 The shared package audio_pkg SHALL hold SILENCE = 8'h80, VOL_RESET = 4'd8, and the FSM state encoding.
REQ-033 The FIFO SHALL be one sub-module, sample_fifo (parameter DEPTH; push, pop, full, empty, level), with storage in an unreset register array and its pointers reset.
REQ-034 sample_feeder SHALL contain only the tick counter, FSM, volume logic and output registers.

Verification
REQ-035 Reset, then idle for 2*PERIOD: DUTY = 0x80, VOL = 8, LEVEL = 0, IN_READY = 1, UNDERRUN never pulses.
REQ-036 Push 0x10..0x1F back-to-back: LEVEL reaches 16, IN_READY = 0, and a 17th push is not accepted; after priming, DUTY steps 0x10, 0x11, ... exactly one per PERIOD clocks, each change one cycle after TICK.
REQ-037 Push 8 samples then stop: after 8 pops, the next TICK gives DUTY = 0x80 and a single UNDERRUN pulse, and the FSM returns to FILL; pushing 8 more resumes playback at the following TICK.
REQ-038 Pulse VOL_UP 10 times, then VOL_DN 20 times: VOL = 15, then VOL = 0; simultaneous UP and DN leaves VOL unchanged.
REQ-039 With the FIFO full, hold IN_VALID across a TICK: exactly one push is accepted in the cycle after the pop, with no loss or duplication of data.
REQ-040 Assert RST_N low mid-PLAY for 3 cycles: outputs take reset values immediately, without waiting for a CLK edge, and stale samples never reappear on DUTY.
